uart_rx_frame_timer: RTL and testbench

Parametrised oversampling timing generator for the UART receive path; the next generation of the RX edge/bit counter.
- Counts oversampling edges per bit and bits per frame.
- Emits three mid-bit sample strobes for the majority-vote sampler, plus bit-end and frame-end pulses.
- Computes frame length from a runtime configuration: data bits, parity enable, stop bits.
- Sits between the RX FSM, which drives enable, and the data/parity/stop samplers.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_frame_len_calc.sv | 31 +++
 rtl/uart_rx_frame_timer.sv | 131 +++++++++++++
 tb/tb_uart_rx_frame_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and frame-length helper for the UART receive timing path.
package uart_pkg;

    localparam int START_BITS     = 1;
    localparam int STOP_BITS      = 1;
    localparam int MIN_DATA_BITS  = 5;
    localparam int MAX_FRAME_BITS = 12;
    localparam int MIN_PRESCALE   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] data_bits;
        logic       par_en;
        logic       stop2;
    } frame_cfg_t;

    // Five bits hold the worst illegal case (15 data bits + parity + two stops + start).
    function automatic logic [4:0] frame_bits(input frame_cfg_t cfg);
        return 5'(START_BITS) + 5'(cfg.data_bits) + 5'(cfg.par_en)
             + 5'(STOP_BITS) + 5'(cfg.stop2);
    endfunction

endpackage

// File: rtl/uart_frame_len_calc.sv
// Combinational frame length and configuration legality for one UART frame.
module uart_frame_len_calc
    import uart_pkg::*;
#(
    parameter int PRESCALE_W    = 6,
    parameter int BIT_CNT_W     = 4,
    parameter int MAX_DATA_BITS = 8
)
(
    input  logic [PRESCALE_W-1:0] prescale,
    input  frame_cfg_t            cfg,
    output logic [BIT_CNT_W-1:0]  frame_len,
    output logic                  legal
);

    logic [4:0] len_full;
    logic       prescale_ok;
    logic       data_ok;
    logic       len_ok;

    assign len_full    = frame_bits(cfg);
    assign frame_len   = BIT_CNT_W'(len_full);

    assign prescale_ok = prescale >= PRESCALE_W'(MIN_PRESCALE);
    assign data_ok     = (cfg.data_bits >= 4'(MIN_DATA_BITS)) &&
                         (cfg.data_bits <= 4'(MAX_DATA_BITS));
    // Guards the bit counter if MAX_DATA_BITS is ever raised past what the frame can hold.
    assign len_ok      = len_full <= 5'(MAX_FRAME_BITS);
    assign legal       = prescale_ok && data_ok && len_ok;

endmodule

// File: rtl/uart_rx_frame_timer.sv
// Oversampling edge/bit counter for the UART RX path with mid-bit sample strobes and frame pulses.
module uart_rx_frame_timer
    import uart_pkg::*;
#(
    parameter int PRESCALE_W    = 6,
    parameter int BIT_CNT_W     = 4,
    parameter int MAX_DATA_BITS = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic                  par_en,
    input  logic                  stop2,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic [2:0]            smp_strb,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  cfg_err
);

    state_t                state;
    logic [PRESCALE_W-1:0] p_lat;
    frame_cfg_t            cfg_lat;
    frame_cfg_t            cfg_live;
    logic [PRESCALE_W-1:0] p_sel;
    frame_cfg_t            cfg_sel;
    logic [BIT_CNT_W-1:0]  frame_len;
    logic                  legal;

    logic [PRESCALE_W-1:0] p_last;
    logic [PRESCALE_W-1:0] mid;
    logic                  in_count;
    logic                  edge_last;
    logic                  bit_last;

    assign cfg_live = {data_bits, par_en, stop2};

    // In IDLE the checker sees the live inputs about to be latched; afterwards only latched values.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch behind.
        p_sel   = p_lat;
        cfg_sel = cfg_lat;
        if (state == IDLE) begin
            p_sel   = prescale;
            cfg_sel = cfg_live;
        end
    end

    uart_frame_len_calc #(
        .PRESCALE_W    (PRESCALE_W),
        .BIT_CNT_W     (BIT_CNT_W),
        .MAX_DATA_BITS (MAX_DATA_BITS)
    ) u_len_calc (
        .prescale  (p_sel),
        .cfg       (cfg_sel),
        .frame_len (frame_len),
        .legal     (legal)
    );

    assign p_last    = p_lat - PRESCALE_W'(1);
    assign mid       = p_lat >> 1;
    assign in_count  = state == COUNT;
    assign edge_last = edge_count == p_last;
    assign bit_last  = bit_count == (frame_len - BIT_CNT_W'(1));

    assign smp_strb   = in_count ? {edge_count == (mid + PRESCALE_W'(1)),
                                    edge_count == mid,
                                    edge_count == (mid - PRESCALE_W'(1))} : 3'b000;
    assign bit_done   = in_count && edge_last;
    assign frame_done = bit_done && bit_last;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop here samples pre-edge values.
        if (!rst) begin
            state      <= IDLE;
            p_lat      <= '0;
            cfg_lat    <= '0;
            edge_count <= '0;
            bit_count  <= '0;
            cfg_err    <= 1'b0;
        end else if (!enable) begin
            // Abort or normal release: every state falls back to IDLE with clean counters.
            state      <= IDLE;
            edge_count <= '0;
            bit_count  <= '0;
            cfg_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    p_lat      <= prescale;
                    cfg_lat    <= cfg_live;
                    edge_count <= '0;
                    bit_count  <= '0;
                    if (legal) begin
                        state <= COUNT;
                    end else begin
                        state   <= ERR;
                        cfg_err <= 1'b1;
                    end
                end
                COUNT: begin
                    if (edge_last) begin
                        edge_count <= '0;
                        if (bit_last) begin
                            state     <= HOLD;
                            bit_count <= '0;
                        end else begin
                            bit_count <= bit_count + BIT_CNT_W'(1);
                        end
                    end else begin
                        edge_count <= edge_count + PRESCALE_W'(1);
                    end
                end
                HOLD, ERR: begin
                    edge_count <= '0;
                    bit_count  <= '0;
                end
                default: begin
                    state      <= IDLE;
                    edge_count <= '0;
                    bit_count  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Scoreboard bench for uart_rx_frame_timer: directed frames queue expected strobe/pulse events.
module tb_uart_rx_frame_timer;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [3:0]    data_bits = '0;
    logic          par_en = 1'b0;
    logic          stop2 = 1'b0;
    logic [PW-1:0] edge_count;
    logic [BW-1:0] bit_count;
    logic [2:0]    smp_strb;
    logic          bit_done;
    logic          frame_done;
    logic          cfg_err;

    uart_rx_frame_timer #(
        .PRESCALE_W    (PW),
        .BIT_CNT_W     (BW),
        .MAX_DATA_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .prescale   (prescale),
        .data_bits  (data_bits),
        .par_en     (par_en),
        .stop2      (stop2),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .smp_strb   (smp_strb),
        .bit_done   (bit_done),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] strb;
        logic       bd;
        logic       fd;
        int         bit_i;
        int         edge_i;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Edge e of bit b is visible on the negedge at cycle start+1+b*p+e; events past cut are dropped.
    task automatic push_frame(input int start, input int p, input int len, input int cut);
        int mid = p / 2;
        for (int b = 0; b < len; b++) begin
            for (int e = 0; e < p; e++) begin
                ev_t ev;
                ev.cyc    = start + 1 + b * p + e;
                ev.strb   = {e == mid + 1, e == mid, e == mid - 1};
                ev.bd     = (e == p - 1);
                ev.fd     = ev.bd && (b == len - 1);
                ev.bit_i  = b;
                ev.edge_i = e;
                if (ev.cyc <= cut && (ev.strb != 3'b000 || ev.bd))
                    exp_q.push_back(ev);
            end
        end
    endtask

    // Monitor: every visible strobe or pulse must match the head of the scoreboard.
    ev_t mon_ev;
    always @(negedge clk) begin
        if (smp_strb != 3'b000 || bit_done || frame_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: cyc=%0d strb=%b bd=%b fd=%b bit=%0d edge=%0d",
                         cyc, smp_strb, bit_done, frame_done, bit_count, edge_count);
            end else begin
                mon_ev = exp_q.pop_front();
                check("event{cyc,strb,bd,fd,bit,edge}",
                      {32'(cyc), smp_strb, bit_done, frame_done, 8'(bit_count), 8'(edge_count)},
                      {32'(mon_ev.cyc), mon_ev.strb, mon_ev.bd, mon_ev.fd,
                       8'(mon_ev.bit_i), 8'(mon_ev.edge_i)});
            end
        end
    end

    task automatic start_frame(input int p, input int db, input logic par, input logic st,
                               output int start);
        @(negedge clk);
        prescale  = PW'(p);
        data_bits = 4'(db);
        par_en    = par;
        stop2     = st;
        enable    = 1'b1;
        start     = cyc;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_events", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Drain the frame, confirm HOLD keeps counters at zero, then release enable.
    task automatic finish_frame(input int budget);
        wait_drain(budget);
        repeat (3) @(negedge clk);
        check("hold_counters", {56'(edge_count), 8'(bit_count)}, 64'd0);
        check("hold_cfg_err", 64'(cfg_err), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        check("idle_counters", {56'(edge_count), 8'(bit_count)}, 64'd0);
    endtask

    task automatic err_case(input int p, input int db);
        @(negedge clk);
        prescale  = PW'(p);
        data_bits = 4'(db);
        par_en    = 1'b0;
        stop2     = 1'b0;
        enable    = 1'b1;
        repeat (3) @(negedge clk);
        check("err_flag_set", 64'(cfg_err), 64'd1);
        check("err_counters", {56'(edge_count), 8'(bit_count)}, 64'd0);
        enable = 1'b0;
        @(negedge clk);
        check("err_flag_cleared", 64'(cfg_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s;

        // Reset state
        #2;
        check("reset_outputs",
              {40'd0, 8'(edge_count), 8'(bit_count), smp_strb, bit_done, frame_done, cfg_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {56'(edge_count), 8'(bit_count)}, 64'd0);

        // 8x oversampling, 8N1: frame_len 10, frame_done 80 cycles after enable
        start_frame(8, 8, 1'b0, 1'b0, s);
        push_frame(s, 8, 10, s + 1000);
        finish_frame(200);

        // 16x, 7 data + parity + 2 stop: frame_len 11, 176 cycles
        start_frame(16, 7, 1'b1, 1'b1, s);
        push_frame(s, 16, 11, s + 1000);
        finish_frame(400);

        // Odd prescale 5: strobes at edges 1,2,3; wrap after edge 4; 5N1 -> 7 bits
        start_frame(5, 5, 1'b0, 1'b0, s);
        push_frame(s, 5, 7, s + 1000);
        finish_frame(100);

        // Minimum prescale with the longest frame: 4x, 8 data + parity + 2 stop -> 12 bits
        start_frame(4, 8, 1'b1, 1'b1, s);
        push_frame(s, 4, 12, s + 1000);
        finish_frame(100);

        // Abort at bit 4 edge 2, then a clean restart
        start_frame(8, 8, 1'b0, 1'b0, s);
        push_frame(s, 8, 10, s + 35);
        repeat (35) @(negedge clk);
        check("abort_point", {56'(edge_count), 8'(bit_count)}, {56'd2, 8'd4});
        enable = 1'b0;
        @(negedge clk);
        check("abort_counters", {56'(edge_count), 8'(bit_count)}, 64'd0);
        check("abort_no_pending", 64'(exp_q.size()), 64'd0);
        start_frame(8, 8, 1'b0, 1'b0, s);
        push_frame(s, 8, 10, s + 1000);
        finish_frame(200);

        // Illegal configurations
        err_case(3, 8);
        err_case(8, 9);
        err_case(8, 4);

        // Inputs changed mid-frame are ignored: timing stays at 6x, 7 bits
        start_frame(6, 5, 1'b0, 1'b0, s);
        push_frame(s, 6, 7, s + 1000);
        repeat (10) @(negedge clk);
        prescale  = PW'(12);
        data_bits = 4'd8;
        par_en    = 1'b1;
        stop2     = 1'b1;
        finish_frame(100);

        // Asynchronous reset mid-frame at bit 2 edge 3
        start_frame(8, 8, 1'b0, 1'b0, s);
        push_frame(s, 8, 10, s + 20);
        repeat (20) @(negedge clk);
        check("pre_reset_point", {56'(edge_count), 8'(bit_count)}, {56'd3, 8'd2});
        #2;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        check("async_reset_outputs",
              {40'd0, 8'(edge_count), 8'(bit_count), smp_strb, bit_done, frame_done, cfg_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_counters", {56'(edge_count), 8'(bit_count)}, 64'd0);
        check("post_reset_no_pending", 64'(exp_q.size()), 64'd0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
